// File: rtl/core_pkg.sv
// Shared core constants: functional-unit bit positions and the writeback entry layout.
package core_pkg;

  localparam int CORE_NUM_UNITS = 8;
  localparam int CORE_XLEN      = 32;
  localparam int CORE_RD_W      = 5;

  // Same bit order as unit_t and p_signal_start_exe.
  localparam int FSQRT_IDX = 0;
  localparam int DIV_IDX   = 1;
  localparam int FDIV_IDX  = 2;
  localparam int R4_IDX    = 3;
  localparam int FMUL_IDX  = 4;
  localparam int FADD_IDX  = 5;
  localparam int MUL_IDX   = 6;
  localparam int FPU_IDX   = 7;

  typedef struct packed {
    logic [CORE_XLEN-1:0] data;
    logic [CORE_RD_W-1:0] rd;
    logic                 fp;
  } wb_entry_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin request arbiter with an internal next-start pointer.
// WB_FIXED_PRIO_EN selects fixed lowest-index priority instead (no pointer).
module rr_arbiter #(
  parameter int NUM_REQ = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] grant
);

`ifdef WB_FIXED_PRIO_EN
  logic w_unused;
  assign w_unused = clk ^ rst ^ advance;

  always_comb begin
    grant = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[k]) grant = NUM_REQ'(1) << k;
    end
  end
`else
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_gidx;
  logic          w_found;
  int            w_idx;

  // Scan starting at the pointer; the first requester found wins.
  always_comb begin
    grant   = '0;
    w_gidx  = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % NUM_REQ;
      if (!w_found && req[w_idx]) begin
        w_found        = 1'b1;
        grant[w_idx]   = 1'b1;
        w_gidx         = PW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (w_gidx == PW'(NUM_REQ - 1)) ? '0 : w_gidx + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/wb_result_arbiter.sv
// Per-unit 1-entry result buffers drained onto the single writeback port.
// Arbitration is round-robin unless WB_FIXED_PRIO_EN is defined (fixed priority, lowest index).
module wb_result_arbiter
  import core_pkg::*;
#(
  parameter int NUM_UNITS = CORE_NUM_UNITS,
  parameter int XLEN      = CORE_XLEN,
  parameter int RD_W      = CORE_RD_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      res_valid,
  input  logic [NUM_UNITS*XLEN-1:0] res_data,
  input  logic [NUM_UNITS*RD_W-1:0] res_rd,
  input  logic [NUM_UNITS-1:0]      res_fp,
  output logic [NUM_UNITS-1:0]      res_ready,
  output logic [NUM_UNITS-1:0]      unit_stall,
  output logic                      wb_valid,
  output logic [XLEN-1:0]           wb_data,
  output logic [RD_W-1:0]           wb_rd,
  output logic                      wb_fp,
  output logic [NUM_UNITS-1:0]      wb_grant,
  input  logic                      wb_ready,
  input  logic [RD_W-1:0]           q_rd,
  input  logic                      q_fp,
  output logic                      q_hit
);

  logic [NUM_UNITS-1:0] r_buf_valid;
  logic [NUM_UNITS-1:0] r_lock_grant;
  logic                 r_lock;
  wb_entry_t            r_buf [NUM_UNITS];

  logic [NUM_UNITS-1:0] w_arb_req;
  logic [NUM_UNITS-1:0] w_grant;
  logic                 w_accept;
  wb_entry_t            w_sel;

  // While an offer is stalled the arbiter sees only the held source, so neither the
  // grant nor the pointer update can be disturbed by buffers filling in the meantime.
  assign w_arb_req = r_lock ? r_lock_grant : r_buf_valid;

  rr_arbiter #(.NUM_REQ(NUM_UNITS)) u_rr_arbiter (
    .clk     (clk),
    .rst     (rst),
    .req     (w_arb_req),
    .advance (w_accept),
    .grant   (w_grant)
  );

  assign wb_valid   = |r_buf_valid;
  assign wb_grant   = w_grant;
  assign w_accept   = wb_valid & wb_ready;
  assign res_ready  = ~r_buf_valid | (w_grant & {NUM_UNITS{wb_ready}});
  assign unit_stall = ~res_ready & res_valid;

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_grant[i]) w_sel = w_sel | r_buf[i];
    end
  end

  assign wb_data = w_sel.data;
  assign wb_rd   = w_sel.rd;
  assign wb_fp   = w_sel.fp;

  always_comb begin
    q_hit = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (r_buf_valid[i] && r_buf[i].rd == q_rd && r_buf[i].fp == q_fp) q_hit = 1'b1;
    end
    if (!q_fp && q_rd == '0) q_hit = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_buf_valid  <= '0;
      r_lock       <= 1'b0;
      r_lock_grant <= '0;
    end else begin
      for (int i = 0; i < NUM_UNITS; i++) begin
        if (res_valid[i] && res_ready[i]) begin
          r_buf_valid[i] <= 1'b1;
          r_buf[i].data  <= res_data[i*XLEN +: XLEN];
          r_buf[i].rd    <= res_rd[i*RD_W +: RD_W];
          r_buf[i].fp    <= res_fp[i];
        end else if (w_accept && w_grant[i]) begin
          r_buf_valid[i] <= 1'b0;
        end
      end
      r_lock       <= wb_valid & ~wb_ready;
      r_lock_grant <= w_grant;
    end
  end

endmodule
